// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: op codes, FSM state
// encoding and default widths.
package alu_pkg;

    localparam int ALU_N_DEF = 4;
    localparam int ALU_W_DEF = 4;
    localparam int ALU_S_W   = 3;

    typedef enum logic [ALU_S_W-1:0] {
        OP_ZERO  = 3'd0,
        OP_BSUBA = 3'd1,
        OP_ASUBB = 3'd2,
        OP_ADD   = 3'd3,
        OP_XOR   = 3'd4,
        OP_OR    = 3'd5,
        OP_AND   = 3'd6,
        OP_ONES  = 3'd7
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_EXEC = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus between the requesting units, the arbiter and the shared ALU.
// Optional macro ALU_ARB_LOCK_EN adds the per-requester Lock input.
//
// Handshake: Req[k] is a level "valid"; the requester holds Req and its
// OpS/OpA/OpB fields stable until it sees Done[k], and drops Req in that
// same cycle. Done[k] is the one-cycle completion strobe (there is no
// separate ready); Result is valid whenever Done is nonzero.
interface alu_share_arbiter_if
    #(parameter int N = alu_pkg::ALU_N_DEF,
      parameter int W = alu_pkg::ALU_W_DEF);
    import alu_pkg::*;

    logic [N-1:0]       Req;
    logic [3*N-1:0]     OpS;
    logic [W*N-1:0]     OpA;
    logic [W*N-1:0]     OpB;
    logic [2:0]         AluS;
    logic [W-1:0]       AluA;
    logic [W-1:0]       AluB;
    logic [W-1:0]       AluF;
    logic [N-1:0]       Grant;
    logic [N-1:0]       Done;
    logic [W-1:0]       Result;
    logic               Busy;
    arb_state_e         dbg_state;
`ifdef ALU_ARB_LOCK_EN
    logic [N-1:0]       Lock;

    modport master (output Req, OpS, OpA, OpB, AluF, Lock,
                    input  AluS, AluA, AluB, Grant, Done, Result, Busy, dbg_state);
    modport slave  (input  Req, OpS, OpA, OpB, AluF, Lock,
                    output AluS, AluA, AluB, Grant, Done, Result, Busy, dbg_state);
`else
    modport master (output Req, OpS, OpA, OpB, AluF,
                    input  AluS, AluA, AluB, Grant, Done, Result, Busy, dbg_state);
    modport slave  (input  Req, OpS, OpA, OpB, AluF,
                    output AluS, AluA, AluB, Grant, Done, Result, Busy, dbg_state);
`endif

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping past N-1 back to 0.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic [IW-1:0] k;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!vld && req[k]) begin
                vld    = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N requesters. ARB picks a winner and
// registers its op onto the ALU inputs; EXEC captures AluF into Result and
// pulses Done to the winner. Optional macro ALU_ARB_LOCK_EN lets the
// previous winner keep the ALU while it holds Lock.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int N  = ALU_N_DEF,
    parameter  int W  = ALU_W_DEF,
    localparam int IW = $clog2(N)
) (
    input logic                  Clock,
    input logic                  Resetn,
    alu_share_arbiter_if.slave   bus
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  done_q, done_d;
    logic [W-1:0]  result_q, result_d;
    logic          busy_q, busy_d;
    logic [2:0]    alu_s_q, alu_s_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          lock_hit;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_gnt;

    rr_pick #(.N(N)) u_pick (
        .req (bus.Req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

`ifdef ALU_ARB_LOCK_EN
    logic [IW-1:0] prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;

    // A locked previous winner that is still requesting overrides the picker.
    assign lock_hit = prev_vld_q & bus.Req[prev_q] & bus.Lock[prev_q];
    assign win_idx  = lock_hit ? prev_q : pick_idx;
    assign win_gnt  = lock_hit ? (N'(1) << prev_q) : pick_gnt;

    // Remember who won the last grant; invalid until the first grant.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (state_q == ST_ARB && pick_vld) begin
            prev_d     = win_idx;
            prev_vld_d = 1'b1;
        end
    end

    // Previous-winner register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`else
    assign lock_hit = 1'b0;
    assign win_idx  = pick_idx;
    assign win_gnt  = pick_gnt;
`endif

    // Next-state and output logic for the ARB/EXEC sequencer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        busy_d   = busy_q;
        alu_s_d  = alu_s_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        case (state_q)
            ST_ARB: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (pick_vld) begin
                    alu_s_d = bus.OpS[int'(win_idx)*3 +: 3];
                    alu_a_d = bus.OpA[int'(win_idx)*W +: W];
                    alu_b_d = bus.OpB[int'(win_idx)*W +: W];
                    grant_d = win_gnt;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                    // A locked re-grant leaves the rotation untouched.
                    if (!lock_hit) begin
                        ptr_d = (pick_idx == IW'(N-1)) ? '0 : pick_idx + 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                result_d = bus.AluF;
                done_d   = grant_q;
                grant_d  = '0;
                busy_d   = 1'b0;
                state_d  = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Sequencer, pointer, ALU input and result registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_ARB;
            ptr_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            alu_s_q  <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            alu_s_q  <= alu_s_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
        end
    end

    assign bus.AluS      = alu_s_q;
    assign bus.AluA      = alu_a_q;
    assign bus.AluB      = alu_b_q;
    assign bus.Grant     = grant_q;
    assign bus.Done      = done_q;
    assign bus.Result    = result_q;
    assign bus.Busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule
